// File: rtl/shift_engine.sv
// -----------------------------------------------------------------------------
// shift_engine
//
// Command-driven universal shift register. A start strobe in IDLE accepts
// one of HOLD / SL / SR / LOAD / ROL / ROR / ASR. A shift of amt positions
// normally runs one position per clock. busy is high while shifting, and done
// pulses for one cycle when the command completes.
//
// Optional build macro:
//   SHIFT_ENGINE_BARREL_EN - every shift completes on the edge after start,
//                            using a single-cycle shifter. busy is never set.
//
// Ports:
//   clk    in   rising-edge clock
//   clr    in   synchronous active-high reset (priority, aborts a shift)
//   din    in   [WIDTH]  parallel load data
//   op     in   [3]      operation code, sampled with start
//   amt    in   [AMT_W]  shift count, sampled with start
//   start  in   command strobe, honoured only in IDLE
//   srsi   in   right-shift fill bit, sampled with start
//   slsi   in   left-shift fill bit, sampled with start
//   dout   out  [WIDTH]  register contents
//   sout   out  last bit shifted or rotated out
//   busy   out  multi-cycle shift in progress
//   done   out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module shift_engine #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic             start,
  input  logic             srsi,
  input  logic             slsi,
  output logic [WIDTH-1:0] dout,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SL   = 3'b001,
    OP_SR   = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ASR  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  // Single-position shift. Returns {bit shifted out, new data}. Both the
  // serial engine and the barrel build use this step, so the two builds give
  // the same results, including the wrap behaviour for large counts.
  function automatic logic [WIDTH:0] shift_one(input op_e o,
                                               input logic [WIDTH-1:0] v,
                                               input logic s,
                                               input logic fl,
                                               input logic fr);
    logic [WIDTH:0] r;
    r = {s, v};
    unique case (o)
      OP_SL:   r = {v[WIDTH-1], v[WIDTH-2:0], fl};
      OP_SR:   r = {v[0], fr, v[WIDTH-1:1]};
      OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  r = {v[0], v[0], v[WIDTH-1:1]};
      OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: r = {s, v};
    endcase
    return r;
  endfunction

  function automatic logic is_shift(input op_e o);
    return (o == OP_SL) || (o == OP_SR) || (o == OP_ROL) ||
           (o == OP_ROR) || (o == OP_ASR);
  endfunction

`ifdef SHIFT_ENGINE_BARREL_EN
  localparam int MAX_AMT = (1 << AMT_W) - 1;

  // Chain of MAX_AMT conditional single steps. Rotations take amt mod WIDTH
  // naturally, and fill or sign saturation falls out of repeated steps.
  function automatic logic [WIDTH:0] barrel(input op_e o,
                                            input logic [WIDTH-1:0] v,
                                            input logic s,
                                            input logic fl,
                                            input logic fr,
                                            input logic [AMT_W-1:0] n);
    logic [WIDTH:0] acc;
    acc = {s, v};
    for (int i = 0; i < MAX_AMT; i++) begin
      if (i < int'(n)) acc = shift_one(o, acc[WIDTH-1:0], acc[WIDTH], fl, fr);
    end
    return acc;
  endfunction
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic             fl_q, fl_d;
  logic             fr_q, fr_d;

  op_e op_in;
  assign op_in = op_e'(op);

  // NOTE: every signal gets a default value first, so no path through this
  // block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    op_d    = op_q;
    fl_d    = fl_q;
    fr_d    = fr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_in == OP_LOAD) begin
            dout_d = din;
            done_d = 1'b1;
          end else if (is_shift(op_in) && (amt != '0)) begin
`ifdef SHIFT_ENGINE_BARREL_EN
            {sout_d, dout_d} = barrel(op_in, dout_q, sout_q, slsi, srsi, amt);
            done_d           = 1'b1;
`else
            op_d    = op_in;
            cnt_d   = amt;
            fl_d    = slsi;
            fr_d    = srsi;
            state_d = S_SHIFT;
`endif
          end else begin
            // HOLD, reserved code, or a zero-length shift: just acknowledge.
            done_d = 1'b1;
          end
        end
      end

      S_SHIFT: begin
        {sout_d, dout_d} = shift_one(op_q, dout_q, sout_q, fl_q, fr_q);
        cnt_d            = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      dout_q  <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the command latches are left out of reset on purpose. They are only
  // read in SHIFT, and every entry into SHIFT reloads them first.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    op_q  <= op_d;
    fl_q  <= fl_d;
    fr_q  <= fr_d;
  end

  assign dout = dout_q;
  assign sout = sout_q;
  assign busy = (state_q == S_SHIFT);
  assign done = done_q;

endmodule

// File: tb/tb_shift_engine.sv
// -----------------------------------------------------------------------------
// tb_shift_engine
//
// Directed bench for shift_engine (WIDTH=8, AMT_W=4). A reference model
// computes the result after k shift steps in closed form. A compare process
// checks dout/sout/busy/done against that model on every falling edge.
// Literal expectations pin the model at key points.
// Build with SHIFT_ENGINE_BARREL_EN defined to check the single-cycle variant.
// -----------------------------------------------------------------------------
module tb_shift_engine;

`ifdef SHIFT_ENGINE_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] din = '0;
  logic [2:0] op = '0;
  logic [3:0] amt = '0;
  logic       start = 1'b0;
  logic       srsi = 1'b0;
  logic       slsi = 1'b0;
  logic [7:0] dout;
  logic       sout, busy, done;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  shift_engine #(.WIDTH(8), .AMT_W(4)) dut (
    .clk(clk), .clr(clr), .din(din), .op(op), .amt(amt), .start(start),
    .srsi(srsi), .slsi(slsi), .dout(dout), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Closed-form result of n shift steps on v: returns {sout, value}.
  function automatic logic [8:0] model_apply(input logic [2:0] o, input logic [7:0] v,
                                             input int n, input logic fl,
                                             input logic fr, input logic s0);
    logic [31:0] x, w, t;
    logic [15:0] d;
    logic [7:0]  val;
    logic        f;
    int          r;
    if (n == 0) return {s0, v};
    case (o)
      3'd1: begin
        x = ({24'b0, v} << n) | (fl ? ((32'd1 << n) - 32'd1) : 32'd0);
        return {x[8], x[7:0]};
      end
      3'd2, 3'd6: begin
        f = (o == 3'd6) ? v[7] : fr;
        w = {24'b0, v} | (f ? (((32'd1 << n) - 32'd1) << 8) : 32'd0);
        x = w >> n;
        t = w >> (n - 1);
        return {t[0], x[7:0]};
      end
      3'd4: begin
        r = n % 8;
        d = {v, v} << r;
        val = d[15:8];
        return {val[0], val};
      end
      3'd5: begin
        r = n % 8;
        d = {v, v} >> r;
        val = d[7:0];
        return {val[7], val};
      end
      default: return {s0, v};
    endcase
  endfunction

  // Reference model, advanced on each rising edge from the bench's own inputs.
  logic [7:0] exp_dout = '0;
  logic       exp_sout = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
  bit         m_active = 1'b0;
  logic [2:0] m_op = '0;
  logic [7:0] m_v0 = '0;
  int         m_n = 0, m_k = 0;
  logic       m_fl = 1'b0, m_fr = 1'b0, m_s0 = 1'b0;

  always @(posedge clk) begin : model
    logic [8:0] r;
    int kn;
    if (clr) begin
      m_active <= 1'b0;
      exp_dout <= '0;
      exp_sout <= 1'b0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
    end else if (m_active) begin
      kn = m_k + 1;
      r  = model_apply(m_op, m_v0, kn, m_fl, m_fr, m_s0);
      exp_dout <= r[7:0];
      exp_sout <= r[8];
      m_k      <= kn;
      exp_done <= (kn == m_n);
      exp_busy <= (kn != m_n);
      m_active <= (kn != m_n);
    end else begin
      exp_done <= 1'b0;
      if (start) begin
        if (op == 3'd3) begin
          exp_dout <= din;
          exp_done <= 1'b1;
        end else if ((op inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) && (amt != 4'd0)) begin
          if (BARREL) begin
            r = model_apply(op, exp_dout, int'(amt), slsi, srsi, exp_sout);
            exp_dout <= r[7:0];
            exp_sout <= r[8];
            exp_done <= 1'b1;
          end else begin
            m_active <= 1'b1;
            m_op     <= op;
            m_v0     <= exp_dout;
            m_n      <= int'(amt);
            m_k      <= 0;
            m_fl     <= slsi;
            m_fr     <= srsi;
            m_s0     <= exp_sout;
            exp_busy <= 1'b1;
          end
        end else begin
          exp_done <= 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dout", dout, exp_dout);
      check("sout", sout, exp_sout);
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
    end
  end

  // Drive a command at the current falling edge and hold it for one rising edge.
  task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [7:0] d,
                       input logic sl, input logic sr);
    op = o; amt = a; din = d; slsi = sl; srsi = sr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, counting busy cycles seen along the way.
  task automatic wait_done(input string nm, output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) return;
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int nb;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    clr = 1'b0;
    check("rst_dout", dout, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // LOAD A5: visible with done one edge after start.
    issue(3'd3, 4'd7, 8'hA5, 1'b0, 1'b0);
    check("load_dout", dout, 8'hA5);
    check("load_done", done, 1'b1);
    check("load_busy", busy, 1'b0);

    // SL by 3 with fill 1: A5 -> 4B -> 97 -> 2F.
    issue(3'd1, 4'd3, 8'h00, 1'b1, 1'b0);
    if (!BARREL) begin
      check("sl_c0", dout, 8'hA5);
      @(negedge clk); check("sl_c1", dout, 8'h4B); check("sl_c1_busy", busy, 1'b1);
      @(negedge clk); check("sl_c2", dout, 8'h97); check("sl_c2_busy", busy, 1'b1);
      @(negedge clk);
    end
    check("sl_final", dout, 8'h2F);
    check("sl_sout", sout, 1'b1);
    check("sl_done", done, 1'b1);
    check("sl_busy", busy, 1'b0);

    // ASR by 2 on 81 -> E0, sout 0.
    issue(3'd3, 4'd0, 8'h81, 1'b0, 1'b0);
    issue(3'd6, 4'd2, 8'h00, 1'b1, 1'b1);
    wait_done("asr", nb);
    check("asr_final", dout, 8'hE0);
    check("asr_sout", sout, 1'b0);
    check("asr_busy_cycles", nb, BARREL ? 0 : 2);

    // ROR by 9 on 81 -> C0 (rotate by 1), 9 busy cycles.
    issue(3'd3, 4'd0, 8'h81, 1'b0, 1'b0);
    issue(3'd5, 4'd9, 8'h00, 1'b0, 1'b0);
    wait_done("ror", nb);
    check("ror_final", dout, 8'hC0);
    check("ror_sout", sout, 1'b1);
    check("ror_busy_cycles", nb, BARREL ? 0 : 9);

    // ROL by 5 on 01 -> 20. A LOAD FF while busy must be ignored.
    issue(3'd3, 4'd0, 8'h01, 1'b0, 1'b0);
    issue(3'd4, 4'd5, 8'h00, 1'b0, 1'b0);
    if (!BARREL) issue(3'd3, 4'd0, 8'hFF, 1'b0, 1'b0);
    wait_done("rol", nb);
    check("rol_final", dout, 8'h20);
    check("rol_sout", sout, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rol_single_done", done, 1'b0);
      check("rol_hold", dout, 8'h20);
    end

    // clr during the second cycle of SR by 4 aborts without a done pulse.
    issue(3'd3, 4'd0, 8'h3C, 1'b0, 1'b0);
    issue(3'd2, 4'd4, 8'h00, 1'b0, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_dout", dout, 8'h00);
    check("clr_busy", busy, 1'b0);
    check("clr_done", done, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("clr_no_done", done, 1'b0);
    end

    // HOLD, reserved code and zero-length shift only acknowledge.
    issue(3'd3, 4'd0, 8'h3C, 1'b0, 1'b0);
    issue(3'd0, 4'd5, 8'hFF, 1'b1, 1'b1);
    check("hold_dout", dout, 8'h3C); check("hold_done", done, 1'b1);
    issue(3'd7, 4'd5, 8'hFF, 1'b1, 1'b1);
    check("rsvd_dout", dout, 8'h3C); check("rsvd_done", done, 1'b1);
    issue(3'd1, 4'd0, 8'hFF, 1'b1, 1'b1);
    check("amt0_dout", dout, 8'h3C); check("amt0_done", done, 1'b1);

    // Count wrap: SR by 10 with fill 1 gives all ones, and sout is a fill bit.
    issue(3'd2, 4'd10, 8'h00, 1'b0, 1'b1);
    wait_done("sr_wrap", nb);
    check("sr_wrap", dout, 8'hFF); check("sr_wrap_sout", sout, 1'b1);

    // Back-to-back: SL by 15 with fill 0 issued in the done cycle -> 00.
    issue(3'd1, 4'd15, 8'h00, 1'b0, 1'b1);
    wait_done("sl_wrap", nb);
    check("sl_wrap", dout, 8'h00); check("sl_wrap_sout", sout, 1'b0);

    // ASR by 12 on a negative value saturates to FF.
    issue(3'd3, 4'd0, 8'h96, 1'b0, 1'b0);
    issue(3'd6, 4'd12, 8'h00, 1'b0, 1'b0);
    wait_done("asr_sat", nb);
    check("asr_sat", dout, 8'hFF); check("asr_sat_sout", sout, 1'b1);

    // ROL by 8 comes back to the start value and takes 8 cycles.
    issue(3'd3, 4'd0, 8'h5A, 1'b0, 1'b0);
    issue(3'd4, 4'd8, 8'h00, 1'b0, 1'b0);
    wait_done("rol8", nb);
    check("rol8", dout, 8'h5A); check("rol8_sout", sout, 1'b0);
    check("rol8_busy_cycles", nb, BARREL ? 0 : 8);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
